// File: rtl/qspi_rom_arbiter_pkg.sv
// Shared types for the two-port QSPI ROM arbiter.
// FSM encoding, port index and default starvation limit.
package qspi_rom_arbiter_pkg;

  localparam int STARVE_MAX_DEF = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_ISSUE = S_ISSUE,
    ST_WAIT  = S_WAIT,
    ST_RESP  = S_RESP
  } state_t;

  typedef logic port_t;

  localparam port_t PORT0 = 1'b0;
  localparam port_t PORT1 = 1'b1;

endpackage

// File: rtl/qspi_rom_arbiter_arb.sv
// Fixed-priority arbiter (port 0 first) with a starvation
// counter that hands one grant to port 1 after STARVE_MAX.
module rom_prio_arb
  import qspi_rom_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  req0,
  input  logic  req1,
  input  logic  grant,
  output port_t win
);

  localparam int CW = $clog2(STARVE_MAX + 2);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  logic [CW-1:0] cnt;
  logic          starved;

  assign starved = (cnt == SMAX);

  always_comb begin
    win = PORT0;
    if (req1 && (!req0 || starved))
      win = PORT1;
  end

  // Only port-0 grants made against a waiting port 1 count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (grant) begin
      if (win == PORT1 || !req1)
        cnt <= '0;
      else if (!starved)
        cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/qspi_rom_arbiter.sv
// Two-master arbiter in front of a QSPI flash read engine,
// flagging reads that continue the shared flash stream.
module qspi_rom_arbiter
  import qspi_rom_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int ADDR_W     = 14
) (
  input  logic              wb_clk_i,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic              m0_ack,
  output logic              m1_ack,
  output logic [15:0]       m0_rdata,
  output logic [15:0]       m1_rdata,
  output logic              f_cmd_valid,
  input  logic              f_cmd_ready,
  output logic [ADDR_W-1:0] f_cmd_addr,
  output logic              f_cmd_seq,
  input  logic              f_rsp_valid,
  input  logic [15:0]       f_rsp_data,
  output logic              busy,
  output port_t             owner
);

  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(1);

  state_t            state;
  port_t             win;
  port_t             own;
  logic              grant;
  logic              accept;
  logic [ADDR_W-1:0] pick;
  logic [ADDR_W-1:0] cmd_addr;
  logic              seq_q;
  logic [ADDR_W-1:0] last_addr;
  logic              last_valid;
  logic [ADDR_W:0]   next_last;
  logic              seq_hit;
  logic              init_q;
  logic              init_fall;
  logic [15:0]       rdata0;
  logic [15:0]       rdata1;

  rom_prio_arb #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clk  (wb_clk_i),
    .rst_n(rst_n),
    .req0 (m0_req),
    .req1 (m1_req),
    .grant(grant),
    .win  (win)
  );

  assign grant = (state == ST_IDLE) && init_done
              && (m0_req || m1_req);
  assign accept = f_cmd_valid && f_cmd_ready;
  assign pick = ((win == PORT1) ? m1_addr : m0_addr)
              & ALIGN;

  // One extra bit keeps 0x3FFE -> 0x0000 from matching.
  assign next_last = {1'b0, last_addr}
                   + (ADDR_W + 1)'(2);
  assign seq_hit = last_valid
                && (next_last == {1'b0, pick});
  assign init_fall = init_q && !init_done;

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      own        <= PORT0;
      cmd_addr   <= '0;
      seq_q      <= 1'b0;
      last_addr  <= '0;
      last_valid <= 1'b0;
      init_q     <= 1'b0;
      rdata0     <= 16'h0000;
      rdata1     <= 16'h0000;
    end else begin
      init_q <= init_done;
      if (accept) begin
        last_addr  <= cmd_addr;
        last_valid <= 1'b1;
      end
      if (init_fall)
        last_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (grant) begin
            own      <= win;
            cmd_addr <= pick;
            seq_q    <= seq_hit;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (f_cmd_ready)
            state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (f_rsp_valid) begin
            if (own == PORT1)
              rdata1 <= f_rsp_data;
            else
              rdata0 <= f_rsp_data;
            state <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign f_cmd_valid = (state == ST_ISSUE);
  assign f_cmd_seq   = f_cmd_valid && seq_q;
  assign f_cmd_addr  = cmd_addr;
  assign m0_ack   = (state == ST_RESP) && (own == PORT0);
  assign m1_ack   = (state == ST_RESP) && (own == PORT1);
  assign m0_rdata = rdata0;
  assign m1_rdata = rdata1;
  assign busy     = (state != ST_IDLE);
  assign owner    = own;

endmodule

// File: doc/qspi_rom_arbiter.md
QSPI_ROM_ARBITER -- requirements
Module: qspi_rom_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: maximum consecutive port-0 grants while port 1 is pending.
REQ-002 SHALL have parameter ADDR_W, default 14: flash byte-address width.
REQ-003 wb_clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 init_done  in  1  flash startup/continuous-read setup complete; no grants while low.
REQ-006 m0_req, m1_req  in  1 each  read request, held high until the matching ack.
REQ-007 m0_addr, m1_addr  in  ADDR_W each  byte address; bit 0 is ignored and forced to 0 downstream.
REQ-008 m0_ack, m1_ack  out  1 each  one-cycle pulse; the matching rdata is valid in the same cycle.
REQ-009 m0_rdata, m1_rdata  out  16 each  registered read word; holds its value until the next ack on that port.
REQ-010 f_cmd_valid  out  1 / f_cmd_ready  in  1  command handshake to the flash transaction engine.
REQ-011 f_cmd_addr  out  ADDR_W  word-aligned command address.
REQ-012 f_cmd_seq  out  1  engine may skip re-addressing and only clock out the next word.
REQ-013 f_rsp_valid  in  1 / f_rsp_data  in  16  response pulse with the read word.
REQ-014 busy  out  1  high in any state except IDLE.
REQ-015 owner  out  1  port of the current or most recent grant.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE: if init_done is high and any request is pending, latch the arbitration winner and its address, then go to ISSUE next cycle.
REQ-018 ISSUE: f_cmd_valid=1; on f_cmd_valid&&f_cmd_ready, go to WAIT; f_cmd_addr and f_cmd_seq stay stable until accepted.
REQ-019 WAIT: on f_rsp_valid, capture f_rsp_data into the owner's rdata and go to RESP; f_rsp_valid outside WAIT is ignored.
REQ-020 RESP: pulse the owner's ack for exactly one cycle, then return to IDLE; minimum request-to-ack latency is 3 cycles plus engine latency.
REQ-021 Arbitration: port 0 wins when both are pending, unless the starvation count equals STARVE_MAX; in that case port 1 wins.
REQ-022 Starvation count: +1 on each port-0 grant made while m1_req is high; cleared on any port-1 grant or when m1_req is low at grant time; saturates at STARVE_MAX.
REQ-023 f_cmd_seq=1 iff last_valid && cmd_addr == last_addr + 2, computed at full width without wrap; 0x3FFE to 0x0000 is NOT sequential.
REQ-024 last_addr and last_valid update at each command acceptance, regardless of owner; the flash stream is shared.
REQ-025 A request withdrawn before its grant is simply not served; the owner's request is latched, so withdrawal after grant does not abort the transaction.
REQ-026 A falling edge of init_done clears last_valid; an in-flight transaction still completes.
REQ-027 Exactly one command is outstanding at a time; no new grant is made before RESP.

Reset
REQ-028 While rst_n is low: state=IDLE; all ack, f_cmd_valid, f_cmd_seq, busy, owner, last_valid and the starvation count = 0; rdata=16'h0000; f_cmd_addr=0.
REQ-029 Reset asserted mid-transaction SHALL abort it with no ack; the first command after reset has f_cmd_seq=0.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the port-index type and the default STARVE_MAX.
REQ-031 Arbitration plus the starvation counter SHALL be a sub-module, rom_prio_arb; the FSM and sequential tracking stay in the top level.

Verification
REQ-032 init_done=0, m0_req at 0x0100 -> no f_cmd_valid; init_done=1 -> command 0x0100 with seq=0, then m0_ack with rdata equal to the engine word.
REQ-033 m0 reads 0x0100 then 0x0102 -> second command has f_cmd_seq=1; a following read of 0x0200 -> seq=0.
REQ-034 m0 and m1 both held continuously -> grant order 0,0,0,0,1,0,0,0,0,1 with STARVE_MAX=4.
REQ-035 m0 at 0x3FFE then 0x0000 -> second command has seq=0; m1 at 0x0010 following m0 at 0x000E -> seq=1.
REQ-036 f_cmd_ready held low for 10 cycles -> f_cmd_addr and f_cmd_seq stable throughout, no ack; a spurious f_rsp_valid in IDLE -> no ack, rdata unchanged.
REQ-037 rst_n asserted during WAIT -> no ack, all outputs at reset values; the next command has seq=0.
